voice_phase_mixer: RTL and testbench

- Sits directly downstream of the 48 kHz slot-event generator; consumes its one-hot per-cycle service strobes.
- On each strobe, services one voice: advances its phase accumulator and adds its sawtooth contribution to a mix sum.
- After the last voice of the frame is serviced, emits one saturated 16-bit signed sample per 48 kHz frame toward the audio output stage.
- Voice pitch and gate are written by the MIDI control logic through a simple write port.

---
 rtl/voice_phase_mixer.sv | 179 +++++++++++++++++
 tb/tb_voice_phase_mixer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/voice_phase_mixer.sv
// Purpose: services one voice per event strobe (phase advance + sawtooth) and mixes them into one saturated sample per frame.
// Latency: the event for the last voice at cycle T gives sample_valid at T+3; events on consecutive cycles are fully pipelined.
// Backpressure: none; every strobe is consumed, and a sample is emitted only when the last voice is serviced.
module voice_phase_mixer #(
    parameter int NUM_VOICES = 36,
    parameter int EVT_W      = 37,
    parameter int PHASE_W    = 24,
    parameter int SAMPLE_W   = 16,
    parameter int ACC_W      = 22,
    parameter int MIX_SHIFT  = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [EVT_W-1:0]    events,
    input  logic                cfg_we,
    input  logic [5:0]          cfg_voice,
    input  logic [PHASE_W-1:0]  cfg_inc,
    input  logic                cfg_on,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid,
    output logic                collision_err
);

    localparam int IDX_W = 6;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
    localparam logic [SAMPLE_W-1:0] MSB_MASK = {1'b1, {(SAMPLE_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

    // Per-voice state
    logic [PHASE_W-1:0]    phase [NUM_VOICES];
    logic [PHASE_W-1:0]    inc   [NUM_VOICES];
    logic [NUM_VOICES-1:0] on_vec;

    // Stage 1 -> 2 registers
    logic               s1_vld;
    logic [IDX_W-1:0]   s1_idx;
    logic [PHASE_W-1:0] s1_phase;
    logic [PHASE_W-1:0] s1_inc;
    logic               s1_on;

    // Stage 2 -> 3 registers
    logic                s2_vld;
    logic                s2_last;
    logic [SAMPLE_W-1:0] s2_contrib;

    logic signed [ACC_W-1:0] acc;

    // Only the low NUM_VOICES event bits select voices; the rest are ignored.
    logic [NUM_VOICES-1:0] ev;
    logic                  unused_ev_hi;
    assign ev           = events[NUM_VOICES-1:0];
    assign unused_ev_hi = ^events[EVT_W-1:NUM_VOICES];

    logic               enc_hit;
    logic [IDX_W-1:0]   enc_idx;
    logic               multi_hot;
    logic [PHASE_W-1:0] rd_phase;
    logic [PHASE_W-1:0] wb_phase;
    logic [SAMPLE_W-1:0] contrib;
    logic               cfg_ok;

    // Lowest set event bit wins.
    always_comb begin
        enc_hit = 1'b0;
        enc_idx = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (ev[i]) begin
                enc_hit = 1'b1;
                enc_idx = IDX_W'(i);
            end
        end
    end

    assign multi_hot = |(ev & (ev - NUM_VOICES'(1)));
    assign cfg_ok    = cfg_we && (cfg_voice < IDX_W'(NUM_VOICES));

    // Stage 2 arithmetic: contribution uses the pre-increment phase, re-biased to signed.
    assign wb_phase = s1_on ? (s1_phase + s1_inc) : '0;
    assign contrib  = s1_on ? (s1_phase[PHASE_W-1 -: SAMPLE_W] ^ MSB_MASK) : '0;

    // A back-to-back service of the same voice must see the phase stage 2 is about to write.
    assign rd_phase = (s1_vld && (s1_idx == enc_idx)) ? wb_phase : phase[enc_idx];

    // Stage 1: capture the selected voice state and track multi-hot strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld        <= 1'b0;
            s1_idx        <= '0;
            s1_phase      <= '0;
            s1_inc        <= '0;
            s1_on         <= 1'b0;
            collision_err <= 1'b0;
        end else begin
            s1_vld <= enc_hit;
            if (enc_hit) begin
                s1_idx   <= enc_idx;
                s1_phase <= rd_phase;
                s1_inc   <= inc[enc_idx];
                s1_on    <= on_vec[enc_idx];
            end
            if (multi_hot) begin
                collision_err <= 1'b1;
            end
        end
    end

    // Voice state: stage-2 writeback first, so a same-voice config write overrides it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                phase[v] <= '0;
                inc[v]   <= '0;
            end
            on_vec <= '0;
        end else begin
            if (s1_vld) begin
                phase[s1_idx] <= wb_phase;
            end
            if (cfg_ok) begin
                inc[cfg_voice]    <= cfg_inc;
                on_vec[cfg_voice] <= cfg_on;
                if (!cfg_on) begin
                    phase[cfg_voice] <= '0;
                end
            end
        end
    end

    // Stage 2 register: hand the contribution and frame-end marker to the mixer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_vld     <= 1'b0;
            s2_last    <= 1'b0;
            s2_contrib <= '0;
        end else begin
            s2_vld     <= s1_vld;
            s2_last    <= (s1_idx == LAST_IDX);
            s2_contrib <= contrib;
        end
    end

    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] shifted;
    logic [SAMPLE_W-1:0]     sat_val;

    // Mix sum, scale-down and clamp to the signed sample range.
    always_comb begin
        sum     = acc + {{(ACC_W-SAMPLE_W){s2_contrib[SAMPLE_W-1]}}, s2_contrib};
        shifted = sum >>> MIX_SHIFT;
        sat_val = shifted[SAMPLE_W-1:0];
        if (shifted > SAT_MAX) begin
            sat_val = SAT_MAX[SAMPLE_W-1:0];
        end else if (shifted < SAT_MIN) begin
            sat_val = SAT_MIN[SAMPLE_W-1:0];
        end
    end

    // Stage 3: accumulate, and on the last voice emit the sample and restart the sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc          <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (s2_vld) begin
                if (s2_last) begin
                    sample_out   <= sat_val;
                    sample_valid <= 1'b1;
                    acc          <= '0;
                end else begin
                    acc <= sum;
                end
            end
        end
    end

endmodule

// File: tb/tb_voice_phase_mixer.sv
// Purpose: self-checking bench for voice_phase_mixer (vector table plus multi-cycle corner sequences).
// Latency: expects sample_valid three cycles after the last-voice strobe.
// Backpressure: none; the scoreboard pops one expectation per sample_valid pulse.
module tb_voice_phase_mixer;

    localparam int NV = 36;

    logic        clk;
    logic        rst;
    logic [36:0] events;
    logic        cfg_we;
    logic [5:0]  cfg_voice;
    logic [23:0] cfg_inc;
    logic        cfg_on;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        collision_err;

    voice_phase_mixer dut (
        .clk           (clk),
        .rst           (rst),
        .events        (events),
        .cfg_we        (cfg_we),
        .cfg_voice     (cfg_voice),
        .cfg_inc       (cfg_inc),
        .cfg_on        (cfg_on),
        .sample_out    (sample_out),
        .sample_valid  (sample_valid),
        .collision_err (collision_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [15:0] val;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        string       name;
        int          lo;
        int          hi;
        logic [23:0] inc;
        logic [15:0] e0;
        logic [15:0] e1;
        logic [15:0] e2;
    } vec_t;
    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every sample pulse must match the oldest expectation, three cycles after its strobe.
    always @(negedge clk) begin
        if (sample_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_sample", 32'(sample_out), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sample", 32'(sample_out), 32'(e.val));
                chk("latency", 32'(cyc), 32'(e.cyc + 3));
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; events = '0; cfg_we = 1'b0;
        #2;
        chk("rst_sample_out", 32'(sample_out), 32'h0);
        chk("rst_sample_valid", 32'(sample_valid), 32'h0);
        chk("rst_collision", 32'(collision_err), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic cfg(input logic [5:0] v, input logic [23:0] inc, input logic on);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_voice = v; cfg_inc = inc; cfg_on = on;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic strobe(input logic [36:0] ev);
        @(posedge clk); #1;
        events = ev;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            events = '0;
        end
    endtask

    // One full frame of one-hot strobes 0..35; optionally a config write alongside strobe inj_v.
    task automatic run_frame(input logic [15:0] exp_val, input int inj_v,
                             input logic [5:0] cv, input logic [23:0] ci, input logic co);
        for (int v = 0; v < NV; v++) begin
            @(posedge clk); #1;
            events    = 37'(1) << v;
            cfg_we    = (v == inj_v);
            cfg_voice = cv; cfg_inc = ci; cfg_on = co;
            if (v == NV - 1) exp_q.push_back('{exp_val, cyc});
        end
        @(posedge clk); #1;
        events = '0; cfg_we = 1'b0;
    endtask

    task automatic frame(input logic [15:0] exp_val);
        run_frame(exp_val, -1, 6'd0, 24'd0, 1'b0);
    endtask

    task automatic drain();
        idle(6);
        chk("drain", 32'(exp_q.size()), 32'h0);
    endtask

    task automatic add_vec(input string n, input int lo, input int hi, input logic [23:0] inc,
                           input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2);
        vec_t t;
        t.name = n; t.lo = lo; t.hi = hi; t.inc = inc; t.e0 = e0; t.e1 = e1; t.e2 = e2;
        vq.push_back(t);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; events = '0; cfg_we = 1'b0; cfg_voice = '0; cfg_inc = '0; cfg_on = 1'b0;

        add_vec("v0_saw",        0,  0,  24'h010000, 16'hFC00, 16'hFC08, 16'hFC10);
        add_vec("all_on_neg",    0,  35, 24'h000000, 16'h8000, 16'h8000, 16'h8000);
        add_vec("v3_wrap_dec",   3,  3,  24'hFFFFFF, 16'hFC00, 16'h03FF, 16'h03FF);
        add_vec("v3_wrap_half",  3,  3,  24'h800000, 16'hFC00, 16'h0000, 16'hFC00);
        add_vec("all_off",       -1, -1, 24'h000000, 16'h0000, 16'h0000, 16'h0000);
        add_vec("all_on_pos",    0,  35, 24'hFFFFFF, 16'h8000, 16'h7FFF, 16'h7FFF);
        add_vec("v35_last",      35, 35, 24'h400000, 16'hFC00, 16'hFE00, 16'h0000);
        add_vec("v0_v1",         0,  1,  24'h010000, 16'hF800, 16'hF810, 16'hF820);

        foreach (vq[i]) begin
            do_reset();
            if (vq[i].lo >= 0) begin
                for (int v = vq[i].lo; v <= vq[i].hi; v++) cfg(6'(v), vq[i].inc, 1'b1);
            end
            frame(vq[i].e0);
            frame(vq[i].e1);
            frame(vq[i].e2);
            drain();
            chk({"hold_", vq[i].name}, 32'(sample_out), 32'(vq[i].e2));
        end

        // Wrap with a large increment, then switch to a small one.
        do_reset();
        cfg(6'd3, 24'hFFFFFF, 1'b1);
        frame(16'hFC00);
        frame(16'h03FF);
        cfg(6'd3, 24'h000002, 1'b1);
        frame(16'h03FF);
        frame(16'hFC00);
        drain();

        // Ignored high bit, then multi-hot: only voice 0 serviced, partial sum carried into the frame.
        do_reset();
        cfg(6'd0, 24'h010000, 1'b1);
        cfg(6'd1, 24'h010000, 1'b1);
        strobe(37'h10_0000_0000);
        idle(1);
        chk("collision_high_bit", 32'(collision_err), 32'h0);
        strobe(37'h3);
        idle(1);
        chk("collision_set", 32'(collision_err), 32'h1);
        frame(16'hF408);
        drain();
        chk("collision_sticky", 32'(collision_err), 32'h1);

        // Same voice on consecutive cycles must use forwarded phases.
        do_reset();
        cfg(6'd0, 24'h010000, 1'b1);
        strobe(37'h1);
        strobe(37'h1);
        strobe(37'h1);
        frame(16'hF030);
        drain();

        // Gate-off write to voice 5 in the same cycle as its stage-2 writeback clears the phase.
        do_reset();
        cfg(6'd5, 24'h010000, 1'b1);
        run_frame(16'hFC00, 6, 6'd5, 24'h010000, 1'b0);
        frame(16'h0000);
        cfg(6'd5, 24'h010000, 1'b1);
        frame(16'hFC00);
        drain();

        // Reset mid-frame discards the partial sum.
        do_reset();
        cfg(6'd0, 24'h010000, 1'b1);
        frame(16'hFC00);
        drain();
        strobe(37'h3);
        for (int v = 0; v <= 17; v++) strobe(37'(1) << v);
        @(posedge clk); #2;
        chk("pre_rst_out", 32'(sample_out), 32'hFC00);
        chk("pre_rst_collision", 32'(collision_err), 32'h1);
        rst = 1'b1; events = '0;
        #1;
        chk("mid_rst_out", 32'(sample_out), 32'h0);
        chk("mid_rst_valid", 32'(sample_valid), 32'h0);
        chk("mid_rst_collision", 32'(collision_err), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        frame(16'h0000);
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
